// File: rtl/pipe_pkg.sv
// Shared ID->EXE payload definitions.
// Purpose : one place that defines the data and control payload layouts,
//           so the ID stage packs and the EXE stage unpacks the same bits.
// Contents: payload widths, field offsets, and packed structs per payload.
package pipe_pkg;

    localparam int IDEX_DATA_W = 133;  // pc 32 + imm 32 + rdata1 32 + rdata2 32 + rd 5
    localparam int IDEX_CTRL_W = 8;    // alusrc, regwrite, memwrite, memread, branch, aluop[2:0]

    // Data payload field LSB positions (pc is the most significant field).
    localparam int RD_LSB  = 0;
    localparam int RS2_LSB = 5;
    localparam int RS1_LSB = 37;
    localparam int IMM_LSB = 69;
    localparam int PC_LSB  = 101;

    // Control payload bit positions.
    localparam int ALUOP_LSB = 0;
    localparam int BRANCH    = 3;
    localparam int MEMREAD   = 4;
    localparam int MEMWRITE  = 5;
    localparam int REGWRITE  = 6;
    localparam int ALUSRC    = 7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [4:0]  rd;
    } idex_data_t;

    typedef struct packed {
        logic       alusrc;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       branch;
        logic [2:0] aluop;
    } idex_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// Single pipeline slot: valid bit plus data and control payload registers.
// Purpose : building block for the main and skid entries of the ID->EXE stage.
// Ports   : clk, rst (sync, active-high)
//           load      - capture load_data/load_ctrl and become valid
//           clear     - become invalid (normal drain)
//           flush     - become invalid, dominates load
//           load_data, load_ctrl - payload to capture
//           valid, data, ctrl    - registered slot contents
// Whenever the slot becomes invalid its ctrl is zeroed and its data is held,
// so an empty slot never presents live control bits.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // NOTE: non-blocking assignments for all state so every slot samples
    // the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data is reset as well, because out_data must read 0
            // after reset; this is a handful of flops, not a memory array.
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (flush || (clear && !load)) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/id_exe_skid_stage.sv
// Elastic ID->EXE pipeline stage with a two-entry skid buffer.
// Purpose : carries the decoded instruction from ID to EXE under a
//           valid/ready handshake with a registered in_ready, inserts
//           zero-control bubbles on flush, and counts back-pressure cycles.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready/in_data/in_ctrl     - ID side
//           flush                                 - kill held and incoming work
//           out_valid/out_ready/out_data/out_ctrl - EXE side
//           stall_cnt - saturating count of out_valid & ~out_ready cycles
module id_exe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              in_fire;
    logic              out_fire;
    logic              m_free;
    logic              m_load;
    logic              m_clear;
    logic              s_load;
    logic              s_clear;
    logic [DATA_W-1:0] m_next_data;
    logic [CTRL_W-1:0] m_next_ctrl;

    // in_ready comes straight from the skid valid flop, so no combinational
    // path from out_ready reaches ID. The rst term only holds it low while
    // reset is asserted.
    assign in_ready = ~s_valid & ~rst;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // M can take a new entry when it is empty or being consumed this cycle.
    assign m_free  = ~m_valid | out_fire;
    assign m_load  = m_free & (s_valid | in_fire);
    assign m_clear = m_free & ~s_valid & ~in_fire;

    // S drains into M first; an accepted input goes to S whenever it is not
    // the one refilling M, which keeps order with no loss.
    assign s_load  = in_fire & ~(m_free & ~s_valid);
    assign s_clear = m_free & s_valid & ~s_load;

    assign m_next_data = s_valid ? s_data : in_data;
    assign m_next_ctrl = s_valid ? s_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (m_load),
        .clear     (m_clear),
        .flush     (flush),
        .load_data (m_next_data),
        .load_ctrl (m_next_ctrl),
        .valid     (m_valid),
        .data      (m_data),
        .ctrl      (m_ctrl)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load),
        .clear     (s_clear),
        .flush     (flush),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (s_valid),
        .data      (s_data),
        .ctrl      (s_ctrl)
    );

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;

    // Back-pressure counter; flush does not touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Directed self-checking bench for id_exe_skid_stage (CNT_W = 4 so the
// saturation point is reachable quickly).
module tb_id_exe_skid_stage;
    import pipe_pkg::*;

    localparam int DW = IDEX_DATA_W;
    localparam int CW = IDEX_CTRL_W;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_skid_stage #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Distinctive payload derived from pc, so a whole-vector compare also
    // catches swapped or corrupted fields.
    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        idex_data_t d;
        d.pc     = pc;
        d.imm    = pc + 32'h0000_1000;
        d.rdata1 = ~pc;
        d.rdata2 = {pc[15:0], pc[31:16]};
        d.rd     = pc[6:2];
        return d;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = mk(pc);
        in_ctrl  = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h10, 8'hFF);

        // ---------------- reset ----------------
        #1;
        check("in_ready_during_rst0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_ready_during_rst", in_ready, 0);
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // ---------------- streaming ----------------
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 8'h41);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, mk(32'h100 + 32'(4 * i)));
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_ctrl", out_ctrl, 0);

        // ---------------- back-pressure ----------------
        do_reset();
        drive(1'b1, 32'h100, 8'h01);
        tick();                              // M = 0x100
        out_ready = 1'b0;
        drive(1'b1, 32'h104, 8'h02);
        tick();                              // S = 0x104, stall 1
        check("bp_in_ready_low", in_ready, 0);
        check("bp_m_holds", out_data, mk(32'h100));
        drive(1'b1, 32'h108, 8'h03);         // held by ID while in_ready=0
        tick();                              // stall 2
        check("bp_m_still", out_data, mk(32'h100));
        check("bp_ctrl_m", out_ctrl, 8'h01);
        tick();                              // stall 3
        check("bp_stall_cnt", stall_cnt, 3);
        out_ready = 1'b1;
        check("bp_deliver0", out_data, mk(32'h100));
        tick();                              // 0x100 consumed, S -> M
        check("bp_deliver1", out_data, mk(32'h104));
        check("bp_deliver1_ctrl", out_ctrl, 8'h02);
        check("bp_in_ready_back", in_ready, 1);
        tick();                              // 0x104 consumed, 0x108 accepted
        in_valid = 1'b0;
        check("bp_deliver2", out_data, mk(32'h108));
        check("bp_deliver2_valid", out_valid, 1);
        tick();
        check("bp_empty", out_valid, 0);
        check("bp_stall_final", stall_cnt, 3);

        // ---------------- flush with full skid ----------------
        drive(1'b1, 32'h200, 8'h44);
        tick();                              // M = 0x200
        out_ready = 1'b0;
        drive(1'b1, 32'h204, 8'h45);
        tick();                              // S = 0x204
        check("fl_skid_full", in_ready, 0);
        drive(1'b1, 32'h208, 8'h46);
        flush = 1'b1;
        tick();
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_data_held", out_data, mk(32'h200));
        // Flush also discards an input accepted in the flush cycle.
        drive(1'b1, 32'h300, 8'h47);
        tick();
        check("fl_in_fire_dropped", out_valid, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("fl_never_out", out_valid, 0);
        end

        // ---------------- bubble control ----------------
        drive(1'b1, 32'h400, 8'h60);         // regwrite + memwrite
        tick();
        check("bub_valid", out_valid, 1);
        check("bub_ctrl_live", out_ctrl, 8'h60);
        in_valid = 1'b0;
        tick();
        check("bub_invalid", out_valid, 0);
        check("bub_ctrl_zero", out_ctrl, 0);
        check("bub_data_held", out_data, mk(32'h400));

        // ---------------- saturation ----------------
        do_reset();
        drive(1'b1, 32'h500, 8'h11);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", stall_cnt, 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_max", stall_cnt, 15);
        check("sat_m_held", out_data, mk(32'h500));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_after_flush", stall_cnt, 15);
        check("sat_flush_valid", out_valid, 0);
        rst = 1'b1;
        tick();
        check("sat_after_rst", stall_cnt, 0);
        check("sat_rst_data", out_data, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_skid_stage.md
Name: id_exe_skid_stage

Overview:
Parametrised, elastic successor to the fixed ID->EXE pipeline register. It carries a data payload (pc, imm, rdata1, rdata2, rd) and a control payload (alusrc, regwrite, memwrite, memread, branch, aluop) under a valid/ready handshake. A two-entry skid buffer keeps in_ready registered. Flush inserts bubbles with all control bits zeroed, and a saturating counter records back-pressure cycles. It sits between decode and execute, so EXE stalls propagate to ID without a combinational ready path.

Parameters:
DATA_W, 133, data payload width (pc 32 + imm 32 + rdata1 32 + rdata2 32 + rd 5); never cleared by flush
CTRL_W, 8, control payload width (alusrc, regwrite, memwrite, memread, branch, aluop[2:0]); forced 0 on every bubble
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept; registered, equals ~skid_valid, 0 while rst high
in_data  in  DATA_W  data payload from ID
in_ctrl  in  CTRL_W  control payload from ID
flush  in  1  kill all held and incoming instructions (branch taken / exception)
out_valid  out  1  EXE-side instruction valid
out_ready  in  1  EXE accepts
out_data  out  DATA_W  data payload to EXE
out_ctrl  out  CTRL_W  control payload to EXE; 0 whenever out_valid=0
stall_cnt  out  CNT_W  saturating count of cycles with out_valid & ~out_ready

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high, on clk/rst.
- Storage: main slot M (valid, data, ctrl) drives the outputs. Skid slot S (valid, data, ctrl) is filled only under back-pressure.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle input->output when unstalled. Throughput is 1/cycle with out_ready held high.
- Update order each edge (rst=0, flush=0):
  - If M empty or out_fire: M <= S if S valid (S then empties), else M <= input if in_fire, else M becomes invalid.
  - If M valid and not out_fire and in_fire: S <= input.
  - If S is moving to M and in_fire in the same cycle: input goes to S. No loss, no reordering.
- Invariant: S valid implies M valid. in_ready=0 exactly when S is full.
- Bubble rule: whenever a slot becomes invalid, its ctrl <= 0 and its data holds its old value. out_ctrl is therefore 0 whenever out_valid=0.
- flush: at the next edge M.valid, S.valid, M.ctrl and S.ctrl all go to 0.
  - Flush dominates: an in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by EXE.
  - in_ready is 1 on the cycle after a flush.
- stall_cnt: increments when out_valid & ~out_ready, saturates at 2^CNT_W-1, and is unaffected by flush.
- Reset: at the edge where rst is sampled high, M and S valid, data and ctrl all go to 0, and stall_cnt goes to 0.
  - Outputs after that edge: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - in_ready is 0 while rst is high and 1 on the first cycle after rst goes low.
  - Reset mid-transfer drops all contents. Reset overrides flush.
- Inputs are ignored while in_ready=0. ID must hold in_valid and its payload stable until in_fire.

Decomposition:
- Shared package pipe_pkg:
  - IDEX_DATA_W/IDEX_CTRL_W constants.
  - Field offset constants (PC_LSB, IMM_LSB, RS1_LSB, RS2_LSB, RD_LSB; CTRL bit positions ALUSRC, REGWRITE, MEMWRITE, MEMREAD, BRANCH, ALUOP_LSB).
  - A packed struct typedef per payload, so ID packs and EXE unpacks identically.
- One natural sub-module, pipe_slot: a single valid+data+ctrl register with load/clear/flush inputs and clear-ctrl-on-invalidate. It is instantiated twice (M, S).

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during rst, in_ready=1 the cycle after release.
- Streaming: out_ready=1, push pc=0x100/0x104/0x108 on consecutive cycles -> same pcs on out_data 1 cycle later, in order, in_ready stays 1.
- Back-pressure: out_ready=0 from cycle after pc=0x100 accepted, push 0x104, 0x108 -> 0x104 lands in S, in_ready=0, 0x108 held by ID. Release out_ready -> 0x100, 0x104, 0x108 delivered in order with no duplicates. stall_cnt equals the number of stalled cycles.
- Flush with full skid: M=0x200, S=0x204, in_valid=1 with 0x208, flush=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and 0x208 is never output.
- Bubble control: idle after regwrite=1/memwrite=1 instruction drains -> out_ctrl==0 while out_valid=0, and out_data holds its last value.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Flush leaves it at 15, rst returns it to 0.
